// File: rtl/rtc_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rtc_bus_pkg
//  Description : Shared definitions for the RTC bus arbiter. Contains the
//                FSM state encoding, requester index constants, default bus
//                timing values and the round-robin index helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package rtc_bus_pkg;

    // FSM state encoding (3 bits, five states)
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ADDR    = 3'd1;
    localparam logic [2:0] ST_GAP     = 3'd2;
    localparam logic [2:0] ST_DATA    = 3'd3;
    localparam logic [2:0] ST_RECOVER = 3'd4;

    // Requester indices within req / req_we / req_addr / req_wdata
    localparam logic [1:0] REQ_IRQ = 2'd0;
    localparam logic [1:0] REQ_WR  = 2'd1;
    localparam logic [1:0] REQ_RD  = 2'd2;

    localparam int NUM_REQ = 3;

    // Default bus timing in clocks
    localparam int T_ADDR_DEF = 4;
    localparam int T_GAP_DEF  = 2;
    localparam int T_DATA_DEF = 6;
    localparam int T_REC_DEF  = 4;

    // Next requester index in circular order 0 -> 1 -> 2 -> 0
    function automatic logic [1:0] next_req_idx(input logic [1:0] idx);
        return (idx >= REQ_RD) ? REQ_IRQ : (idx + 2'd1);
    endfunction

endpackage : rtc_bus_pkg
`default_nettype wire

// File: rtl/rtc_bus_prio.sv
`default_nettype none
// ============================================================================
//  Module      : rtc_bus_prio
//  Description : Combinational winner select for the RTC bus arbiter.
//                The search starts at the requester after last_idx and walks
//                the three requesters circularly. Holding last_idx at REQ_RD
//                turns this into plain fixed priority with bit 0 highest.
//  Ports       : req        - request levels, one bit per requester
//                last_idx   - index the search starts after
//                any        - at least one request is pending
//                win_idx    - index of the winning requester
//                win_onehot - one-hot form of win_idx (0 when none)
//  Revision    : 1.0 - initial release
// ============================================================================
module rtc_bus_prio
    import rtc_bus_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] last_idx,
    output logic       any,
    output logic [1:0] win_idx,
    output logic [2:0] win_onehot
);

    logic [3:0] w_req_ext;
    logic [1:0] w_cand;

    // Pad to four bits so an out-of-range candidate simply reads as idle
    assign w_req_ext = {1'b0, req};

    always_comb begin
        any        = 1'b0;
        win_idx    = REQ_IRQ;
        win_onehot = 3'b000;
        w_cand     = last_idx;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = next_req_idx(w_cand);
            if (!any && w_req_ext[w_cand]) begin
                any     = 1'b1;
                win_idx = w_cand;
            end
        end
        if (any) begin
            win_onehot = 3'b001 << win_idx;
        end
    end

endmodule : rtc_bus_prio
`default_nettype wire

// File: rtl/rtc_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rtc_bus_arbiter
//  Description : Arbitrates three requesters (IRQ service, user write,
//                periodic readback) onto a multiplexed RTC bus with
//                active-low AD/CS/RD/RW strobes. Each transaction runs
//                ADDR -> GAP -> DATA -> RECOVER, each phase timed by a shared
//                4-bit down-counter loaded on state entry.
//  Config      : RTC_BUS_RR_EN - when defined, round-robin arbitration with a
//                last-grant register; otherwise fixed priority, bit 0 first.
//  Ports       : clk, reset            - clock, async active-high reset
//                req/req_we            - per-requester request and direction
//                req_addr/req_wdata    - per-requester address / write data,
//                                        requester i in bits [8i+7:8i]
//                gnt                   - one-hot transaction owner, 0 idle
//                done                  - one-clock pulse, last RECOVER clock
//                rdata                 - last read result
//                busy                  - FSM not in IDLE
//                AD, CS, RD, RW        - active-low RTC bus strobes
//                dato_out/dato_oe      - bus drive value and enable
//                dato_in               - sampled bus value
//  Revision    : 1.0 - initial release
// ============================================================================
module rtc_bus_arbiter
    import rtc_bus_pkg::*;
#(
    parameter int T_ADDR = T_ADDR_DEF,
    parameter int T_GAP  = T_GAP_DEF,
    parameter int T_DATA = T_DATA_DEF,
    parameter int T_REC  = T_REC_DEF
)(
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [2:0]  req_we,
    input  logic [23:0] req_addr,
    input  logic [23:0] req_wdata,
    output logic [2:0]  gnt,
    output logic        done,
    output logic [7:0]  rdata,
    output logic        busy,
    output logic        AD,
    output logic        CS,
    output logic        RD,
    output logic        RW,
    output logic [7:0]  dato_out,
    output logic        dato_oe,
    input  logic [7:0]  dato_in
);

    // Counter reload values: a phase of N clocks counts N-1 down to 0
    localparam logic [3:0] c_addr_ld = 4'(T_ADDR - 1);
    localparam logic [3:0] c_gap_ld  = 4'(T_GAP - 1);
    localparam logic [3:0] c_data_ld = 4'(T_DATA - 1);
    localparam logic [3:0] c_rec_ld  = 4'(T_REC - 1);

    logic [2:0] r_state;
    logic [3:0] r_cnt;
    logic       r_we;
    logic [7:0] r_addr;
    logic [7:0] r_wdata;
    logic [2:0] r_gnt;
    logic       r_done;
    logic [7:0] r_rdata;
    logic       r_busy;
    logic       r_ad;
    logic       r_cs;
    logic       r_rd;
    logic       r_rw;
    logic       r_oe;
    logic [7:0] r_dout;

    logic [2:0] w_state_nxt;
    logic [3:0] w_cnt_nxt;
    logic       w_any;
    logic [1:0] w_win_idx;
    logic [2:0] w_win_onehot;
    logic [1:0] w_last_idx;
    logic       w_grant;
    logic       w_last_data;
    logic       w_we_nxt;
    logic [7:0] w_addr_nxt;
    logic [7:0] w_wdata_nxt;
    logic [2:0] w_gnt_nxt;
    logic       w_cs_nxt;
    logic       w_ad_nxt;
    logic       w_rd_nxt;
    logic       w_rw_nxt;
    logic       w_oe_nxt;
    logic [7:0] w_dout_nxt;
    logic       w_done_nxt;

    // ------------------------------------------------------------------
    // Arbitration source: last-grant register or a fixed start point
    // ------------------------------------------------------------------
`ifdef RTC_BUS_RR_EN
    logic [1:0] r_last_gnt;

    // Reset value REQ_RD makes requester 0 the first candidate
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_gnt <= REQ_RD;
        end else if (w_grant) begin
            r_last_gnt <= w_win_idx;
        end
    end

    assign w_last_idx = r_last_gnt;
`else
    // Searching after the last index always begins at bit 0: fixed priority
    assign w_last_idx = REQ_RD;
`endif

    rtc_bus_prio u_prio (
        .req        (req),
        .last_idx   (w_last_idx),
        .any        (w_any),
        .win_idx    (w_win_idx),
        .win_onehot (w_win_onehot)
    );

    assign w_grant     = (r_state == ST_IDLE) && w_any;
    assign w_last_data = (r_state == ST_DATA) && (r_cnt == 4'd0);

    // ------------------------------------------------------------------
    // Next-state and phase counter
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_nxt = ST_ADDR;
                    w_cnt_nxt   = c_addr_ld;
                end
            end
            ST_ADDR: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_GAP;
                    w_cnt_nxt   = c_gap_ld;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_GAP: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_DATA;
                    w_cnt_nxt   = c_data_ld;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_DATA: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_RECOVER;
                    w_cnt_nxt   = c_rec_ld;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_RECOVER: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Transaction capture and output decode. Outputs are decoded from the
    // next state so every pin comes straight off a flop, aligned with the
    // state register and free of decode glitches.
    // ------------------------------------------------------------------
    always_comb begin
        w_we_nxt    = r_we;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_gnt_nxt   = r_gnt;
        if (w_grant) begin
            w_we_nxt    = req_we[w_win_idx];
            w_addr_nxt  = req_addr[{w_win_idx, 3'b000} +: 8];
            w_wdata_nxt = req_wdata[{w_win_idx, 3'b000} +: 8];
            w_gnt_nxt   = w_win_onehot;
        end else if (w_state_nxt == ST_IDLE) begin
            w_gnt_nxt = 3'b000;
        end

        w_cs_nxt   = !((w_state_nxt == ST_ADDR) || (w_state_nxt == ST_GAP) ||
                       (w_state_nxt == ST_DATA));
        w_ad_nxt   = !(w_state_nxt == ST_ADDR);
        // RD/RW only ever drop in DATA, where AD is already high
        w_rd_nxt   = !((w_state_nxt == ST_DATA) && !w_we_nxt);
        w_rw_nxt   = !((w_state_nxt == ST_DATA) &&  w_we_nxt);
        w_oe_nxt   = 1'b0;
        w_dout_nxt = 8'h00;
        if (w_state_nxt == ST_ADDR) begin
            w_oe_nxt   = 1'b1;
            w_dout_nxt = w_addr_nxt;
        end else if (((w_state_nxt == ST_GAP) || (w_state_nxt == ST_DATA)) && w_we_nxt) begin
            // Write data is put on the bus during GAP for setup ahead of RW
            w_oe_nxt   = 1'b1;
            w_dout_nxt = w_wdata_nxt;
        end
        w_done_nxt = (w_state_nxt == ST_RECOVER) && (w_cnt_nxt == 4'd0);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= 8'h00;
            r_wdata <= 8'h00;
            r_gnt   <= 3'b000;
            r_done  <= 1'b0;
            r_rdata <= 8'h00;
            r_busy  <= 1'b0;
            r_ad    <= 1'b1;
            r_cs    <= 1'b1;
            r_rd    <= 1'b1;
            r_rw    <= 1'b1;
            r_oe    <= 1'b0;
            r_dout  <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_we    <= w_we_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_gnt   <= w_gnt_nxt;
            r_done  <= w_done_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_ad    <= w_ad_nxt;
            r_cs    <= w_cs_nxt;
            r_rd    <= w_rd_nxt;
            r_rw    <= w_rw_nxt;
            r_oe    <= w_oe_nxt;
            r_dout  <= w_dout_nxt;
            if (w_last_data && !r_we) begin
                r_rdata <= dato_in;
            end
        end
    end

    assign gnt      = r_gnt;
    assign done     = r_done;
    assign rdata    = r_rdata;
    assign busy     = r_busy;
    assign AD       = r_ad;
    assign CS       = r_cs;
    assign RD       = r_rd;
    assign RW       = r_rw;
    assign dato_out = r_dout;
    assign dato_oe  = r_oe;

endmodule : rtc_bus_arbiter
`default_nettype wire

// File: tb/tb_rtc_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rtc_bus_arbiter
//  Description : Directed self-checking bench for rtc_bus_arbiter: reset
//                state, single read, single write with request drop and
//                post-grant input changes, contention ordering (fixed or
//                RTC_BUS_RR_EN round-robin), reset mid-read, and strobe
//                invariants over random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rtc_bus_arbiter;

    localparam int TA = 4;
    localparam int TG = 2;
    localparam int TD = 6;
    localparam int TR = 4;
    localparam int TXN_CLKS = TA + TG + TD + TR;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  req = 3'b000;
    logic [2:0]  req_we = 3'b000;
    logic [23:0] req_addr = 24'h0;
    logic [23:0] req_wdata = 24'h0;
    logic [2:0]  gnt;
    logic        done;
    logic [7:0]  rdata;
    logic        busy;
    logic        AD, CS, RD, RW;
    logic [7:0]  dato_out;
    logic        dato_oe;
    logic [7:0]  dato_in = 8'h00;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    rtc_bus_arbiter #(
        .T_ADDR (TA),
        .T_GAP  (TG),
        .T_DATA (TD),
        .T_REC  (TR)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .done      (done),
        .rdata     (rdata),
        .busy      (busy),
        .AD        (AD),
        .CS        (CS),
        .RD        (RD),
        .RW        (RW),
        .dato_out  (dato_out),
        .dato_oe   (dato_oe),
        .dato_in   (dato_in)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Walks one transaction clock by clock, starting with the grant edge.
    // Strobe vector is {CS,AD,RD,RW,dato_oe,done,busy}.
    task automatic check_txn(input string tag, input logic [2:0] eg, input logic ewe,
                             input logic [7:0] ea, input logic [7:0] ew,
                             input int drop_k, input int mut_k);
        logic in_a, in_g, in_d, e_oe;
        for (int k = 1; k <= TXN_CLKS; k++) begin
            @(posedge clk);
            @(negedge clk);
            in_a = (k <= TA);
            in_g = (k > TA) && (k <= TA + TG);
            in_d = (k > TA + TG) && (k <= TA + TG + TD);
            e_oe = in_a || ((in_g || in_d) && ewe);
            chk($sformatf("%s_strb_k%0d", tag, k), {25'd0, CS, AD, RD, RW, dato_oe, done, busy},
                {25'd0, !(in_a || in_g || in_d), !in_a, !(in_d && !ewe), !(in_d && ewe),
                 e_oe, (k == TXN_CLKS), 1'b1});
            chk($sformatf("%s_gnt_k%0d", tag, k), {29'd0, gnt}, {29'd0, eg});
            if (e_oe) begin
                chk($sformatf("%s_dout_k%0d", tag, k), {24'd0, dato_out}, {24'd0, in_a ? ea : ew});
            end
            if (k == drop_k) req = 3'b000;
            if (k == mut_k) begin
                req_addr  = ~req_addr;
                req_wdata = ~req_wdata;
                req_we    = ~req_we;
            end
        end
    endtask

    // One clock after done the block must be idle with no grant
    task automatic idle_check(input string tag);
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("%s_idle", tag), {28'd0, gnt, busy}, 32'd0);
        chk($sformatf("%s_idle_strb", tag), {27'd0, CS, AD, RD, RW, dato_oe}, {27'd0, 5'b11110});
    endtask

    logic [2:0] exp_order [4];
    logic [7:0] c_addr_tab [3];
    int cs_hi_run;
    bit seen_low;

    initial begin
        c_addr_tab[0] = 8'h10;
        c_addr_tab[1] = 8'h20;
        c_addr_tab[2] = 8'h30;
`ifdef RTC_BUS_RR_EN
        exp_order[0] = 3'b001; exp_order[1] = 3'b010; exp_order[2] = 3'b100; exp_order[3] = 3'b001;
`else
        exp_order[0] = 3'b001; exp_order[1] = 3'b001; exp_order[2] = 3'b001; exp_order[3] = 3'b001;
`endif

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_strb", {24'd0, CS, AD, RD, RW, dato_oe, done, busy, 1'b0}, {24'd0, 8'b1111_0000});
        chk("rst_gnt", {29'd0, gnt}, 32'd0);
        chk("rst_rdata", {24'd0, rdata}, 32'd0);
        chk("rst_dout", {24'd0, dato_out}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", {28'd0, gnt, busy}, 32'd0);

        // ---------------- single read ----------------
        req_addr  = 24'h04_0000;
        req_we    = 3'b000;
        dato_in   = 8'h59;
        req       = 3'b100;
        check_txn("rd", 3'b100, 1'b0, 8'h04, 8'h00, 1, 0);
        chk("rd_rdata", {24'd0, rdata}, 32'h59);
        idle_check("rd");

        // ---------------- single write, drop in GAP, inputs mutated ----------------
        req_addr  = 24'h00_0B00;
        req_wdata = 24'h00_8600;
        req_we    = 3'b010;
        dato_in   = 8'hEE;
        req       = 3'b010;
        check_txn("wr", 3'b010, 1'b1, 8'h0B, 8'h86, TA + 1, 2);
        chk("wr_rdata_hold", {24'd0, rdata}, 32'h59);
        idle_check("wr");

        // ---------------- contention, all requests held ----------------
        req_addr  = {c_addr_tab[2], c_addr_tab[1], c_addr_tab[0]};
        req_wdata = 24'h00_A500;
        req_we    = 3'b010;
        dato_in   = 8'h3C;
        req       = 3'b111;
        for (int t = 0; t < 4; t++) begin
            case (exp_order[t])
                3'b010:  check_txn($sformatf("ct%0d", t), 3'b010, 1'b1, c_addr_tab[1], 8'hA5,
                                   (t == 3) ? 1 : 0, 0);
                3'b100:  check_txn($sformatf("ct%0d", t), 3'b100, 1'b0, c_addr_tab[2], 8'h00,
                                   (t == 3) ? 1 : 0, 0);
                default: check_txn($sformatf("ct%0d", t), 3'b001, 1'b0, c_addr_tab[0], 8'h00,
                                   (t == 3) ? 1 : 0, 0);
            endcase
            idle_check($sformatf("ct%0d", t));
        end
        chk("ct_rdata", {24'd0, rdata}, 32'h3C);

        // ---------------- reset in DATA of a read ----------------
        req_addr  = 24'h04_0000;
        req_we    = 3'b000;
        dato_in   = 8'h77;
        req       = 3'b100;
        for (int k = 1; k <= TA + TG + 2; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("rstmid_pre_rd", {31'd0, RD}, 32'd0);
        #2 reset = 1'b1;
        #1;
        chk("rstmid_strb", {27'd0, CS, AD, RD, RW, dato_oe}, {27'd0, 5'b11110});
        chk("rstmid_state", {27'd0, gnt, busy, done}, 32'd0);
        req = 3'b000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("rstmid_nodone%0d", k), {31'd0, done}, 32'd0);
        end
        chk("rstmid_rdata", {24'd0, rdata}, 32'd0);
        reset = 1'b0;
        idle_check("rstmid");

        // ---------------- strobe invariants over random traffic ----------------
        cs_hi_run = 0;
        seen_low  = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            chk("inv_rd_rw", {31'd0, (!RD && !RW)}, 32'd0);
            chk("inv_strb_ad", {31'd0, ((!RD || !RW) && !AD)}, 32'd0);
            if (CS) begin
                cs_hi_run++;
            end else begin
                if (seen_low && cs_hi_run > 0) begin
                    chk("inv_cs_gap", {31'd0, (cs_hi_run >= TR)}, 32'd1);
                end
                cs_hi_run = 0;
                seen_low  = 1'b1;
            end
            req       = 3'($urandom_range(0, 7));
            req_we    = 3'($urandom_range(0, 7));
            req_addr  = 24'($urandom);
            req_wdata = 24'($urandom);
            dato_in   = 8'($urandom);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_rtc_bus_arbiter
`default_nettype wire

// File: doc/rtc_bus_arbiter.md
RTC_BUS_ARBITER -- requirements
Module: rtc_bus_arbiter

Interface
REQ-001 The block SHALL have parameter T_ADDR, default 4, which sets the address-phase length in clocks (range 1..15).
REQ-002 The block SHALL have parameter T_GAP, default 2, which sets the number of clocks between the AD rising edge and the data strobe (range 1..15).
REQ-003 The block SHALL have parameter T_DATA, default 6, which sets the RD/RW strobe length in clocks (range 1..15).
REQ-004 The block SHALL have parameter T_REC, default 4, which sets the recovery time with CS high before the next transaction (range 1..15).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: reset, asynchronous and active-high.
REQ-007 The block SHALL have port req, input, 3 bits: per-requester level request. Bit 0 is IRQ service, bit 1 is user write, bit 2 is periodic readback.
REQ-008 The block SHALL have port req_we, input, 3 bits: per-requester write (1) or read (0).
REQ-009 The block SHALL have port req_addr, input, 24 bits: per-requester RTC register address; requester i uses bits [8i+7:8i].
REQ-010 The block SHALL have port req_wdata, input, 24 bits: per-requester write data, packed the same way as req_addr.
REQ-011 The block SHALL have port gnt, output, 3 bits: one-hot owner of the current transaction; it is 0 when idle.
REQ-012 The block SHALL have port done, output, 1 bit: a single-clock pulse at the end of a transaction.
REQ-013 The block SHALL have port rdata, output, 8 bits: the last read result.
REQ-014 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-015 The block SHALL have ports AD, CS, RD and RW, outputs, 1 bit each: active-low RTC bus strobes.
REQ-016 The block SHALL have ports dato_out, output, 8 bits, and dato_oe, output, 1 bit: bus drive value and drive enable. The tristate buffer is built at the top level.
REQ-017 The block SHALL have port dato_in, input, 8 bits: the bus sampled value.

Function
REQ-018 The FSM SHALL have the states IDLE, ADDR, GAP, DATA and RECOVER, with one 4-bit down-counter loaded on each state entry.
REQ-019 In IDLE, if any req bit is high at a clock edge, the block SHALL latch the winner's we/addr/wdata, set gnt, and enter ADDR on that edge.
REQ-020 Arbitration SHALL be fixed priority, bit 0 highest, and SHALL be evaluated only in IDLE.
REQ-021 In ADDR, for T_ADDR clocks, the block SHALL hold CS=0, AD=0, dato_oe=1 and dato_out=addr.
REQ-022 In GAP, for T_GAP clocks, the block SHALL hold CS=0 and AD=1, and SHALL hold dato_oe=1 only if the transaction is a write.
REQ-023 In DATA, for T_DATA clocks, the block SHALL hold CS=0. A write holds RW=0 and dato_out=wdata with dato_oe=1. A read holds RD=0 with dato_oe=0.
REQ-024 For a read, the block SHALL register rdata from dato_in on the last DATA clock, and rdata SHALL otherwise hold its value.
REQ-025 In RECOVER, for T_REC clocks, the block SHALL hold all strobes high and dato_oe=0.
REQ-026 done SHALL be high during the last RECOVER clock, then the block SHALL return to IDLE and clear gnt.
REQ-027 All strobe and data outputs SHALL be registered and glitch-free; RD and RW SHALL never be low at the same time, and RD/RW SHALL never be low while AD is low.
REQ-028 A requester that drops req mid-transaction SHALL NOT abort it; the transaction completes and done still pulses.
REQ-029 A requester still holding req after done SHALL be re-arbitrated in IDLE, with no back-to-back grant in the done cycle.
REQ-030 req_addr, req_wdata and req_we changes after the grant SHALL be ignored.

Reset
REQ-031 While reset is high, the block SHALL force state=IDLE, AD=CS=RD=RW=1, dato_oe=0, dato_out=0, gnt=0, done=0, busy=0, rdata=0 and counter=0.
REQ-032 When reset is asserted mid-transaction, the bus SHALL be released immediately (asynchronously), and no done pulse SHALL be produced.

Configuration
REQ-033 With RTC_BUS_RR_EN defined, arbitration SHALL be round-robin: priority starts at the requester after the last granted one, and after reset bit 0 is first.
REQ-034 With RTC_BUS_RR_EN undefined, arbitration SHALL be fixed priority as in REQ-020, and the last-grant register SHALL be absent.

Structure
REQ-035 Package rtc_bus_pkg SHALL hold the state encoding, the requester index constants (REQ_IRQ=0, REQ_WR=1, REQ_RD=2) and the timing-parameter defaults.
REQ-036 The block SHALL contain one sub-module, rtc_bus_prio, for the combinational winner select (fixed or round-robin); the FSM and counter stay in rtc_bus_arbiter.

Verification
REQ-037 Single read: req=3'b100, addr 0x04, dato_in=0x59 -> CS low 12 clocks, AD low for the first 4 of them, RD low for clocks 7..12, done on clock 16, rdata=0x59.
REQ-038 Single write: req=3'b010, addr 0x0B, wdata 0x86 -> dato_oe=1 for clocks 1..12, RW low for clocks 7..12 with dato_out=0x86, RD stays high, done on clock 16.
REQ-039 Contention with req=3'b111 held -> fixed build grants the order 0,0,0...; RTC_BUS_RR_EN build grants 0,1,2,0.
REQ-040 Request drop: req[1] deasserted in GAP -> the write completes, done pulses, and gnt clears.
REQ-041 Reset mid-operation: reset asserted in DATA of a read -> strobes go to 1 and dato_oe to 0 in the same cycle, no done pulse, rdata=0.
REQ-042 Strobe invariant check over random traffic: RD&RW never both low, RD/RW never low while AD is low, and CS high for at least T_REC clocks between transactions.
